// File: rtl/load_store_unit_if.sv
// Load/store bus: execute-stage request/response plus the DataMemory port.
interface load_store_unit_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            req_funct3;
  logic [31:0]           req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_misaligned;
  logic                  mem_read;
  logic                  mem_write;
  logic [DM_ADDRESS-1:0] mem_a;
  logic [DATA_W-1:0]     mem_wd;
  logic [DATA_W-1:0]     mem_rd;

  // Requester plus memory model side
  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned,
    input  mem_read, mem_write, mem_a, mem_wd
  );

  // Load/store unit side
  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_misaligned,
    output mem_read, mem_write, mem_a, mem_wd
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store front end: byte-to-word addressing, read-modify-write
// for sub-word stores, load extraction with sign/zero extension, fault detection.
module load_store_unit #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input logic             clk,
  input logic             rst_n,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_e;

  state_e                state_q, state_d;
  logic                  wr_q;
  logic [2:0]            f3_q;
  logic [DM_ADDRESS+1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     rd_q;
  logic [DATA_W-1:0]     mem_wd_q;
  logic                  fault_q;

  logic                  req_fault;
  logic                  ready_c, rd_c, wr_c, rv_c;
  logic                  unused_addr_hi;

  // Upper byte-address bits are not decoded: addresses alias across memory.
  assign unused_addr_hi = ^bus.req_addr[31:DM_ADDRESS+2];

  function automatic logic is_fault(input logic wr, input logic [2:0] f3,
                                    input logic [1:0] a);
    logic f;
    f = 1'b0;
    case (f3)
      3'b000:  f = 1'b0;
      3'b001:  f = a[0];
      3'b010:  f = |a;
      3'b100:  f = wr;
      3'b101:  f = wr | a[0];
      default: f = 1'b1;
    endcase
    return f;
  endfunction

  function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] w,
                                                 input logic [2:0] f3,
                                                 input logic [1:0] a);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [DATA_W-1:0]  r;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{(DATA_W-8){b[7]}}, b};
      3'b100:  r = {{(DATA_W-8){1'b0}}, b};
      3'b001:  r = {{(DATA_W-16){h[15]}}, h};
      3'b101:  r = {{(DATA_W-16){1'b0}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] store_merge(input logic [DATA_W-1:0] old,
                                                    input logic [DATA_W-1:0] wd,
                                                    input logic [2:0] f3,
                                                    input logic [1:0] a);
    logic [DATA_W-1:0] r;
    r = old;
    case (f3)
      3'b000: r[{a, 3'b000} +: 8] = wd[7:0];
      3'b001: begin
        if (a[1]) r[31:16] = wd[15:0];
        else      r[15:0]  = wd[15:0];
      end
      default: r = wd;
    endcase
    return r;
  endfunction

  assign req_fault = is_fault(bus.req_write, bus.req_funct3, bus.req_addr[1:0]);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: faults skip memory, SW skips the read, the rest read first
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (req_fault)                                       state_d = S_RESP;
          else if (!bus.req_write || bus.req_funct3 != 3'b010) state_d = S_RD;
          else                                                 state_d = S_WR;
        end
      end
      S_RD:    state_d = wr_q ? S_WR : S_RESP;
      S_WR:    state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded control outputs
  always_comb begin
    ready_c = 1'b0;
    rd_c    = 1'b0;
    wr_c    = 1'b0;
    rv_c    = 1'b0;
    case (state_q)
      S_IDLE:  ready_c = 1'b1;
      S_RD:    rd_c    = 1'b1;
      S_WR:    wr_c    = 1'b1;
      S_RESP:  rv_c    = 1'b1;
      default: ;
    endcase
  end

  // Request latch, read capture and store-data formation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q     <= 1'b0;
      f3_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      mem_wd_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            wr_q    <= bus.req_write;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr[DM_ADDRESS+1:0];
            wdata_q <= bus.req_wdata;
            fault_q <= req_fault;
            if (!req_fault && bus.req_write && bus.req_funct3 == 3'b010)
              mem_wd_q <= bus.req_wdata;
          end
        end
        S_RD: begin
          rd_q <= bus.mem_rd;
          if (wr_q) mem_wd_q <= store_merge(bus.mem_rd, wdata_q, f3_q, addr_q[1:0]);
        end
        default: ;
      endcase
    end
  end

  // Control strobes are forced low while reset is held so no write can land
  assign bus.req_ready       = rst_n & ready_c;
  assign bus.mem_read        = rst_n & rd_c;
  assign bus.mem_write       = rst_n & wr_c;
  assign bus.resp_valid      = rst_n & rv_c;
  assign bus.resp_misaligned = bus.resp_valid & fault_q;
  assign bus.resp_rdata      = (bus.resp_valid && !wr_q && !fault_q)
                               ? load_ext(rd_q, f3_q, addr_q[1:0]) : '0;
  assign bus.mem_a           = addr_q[DM_ADDRESS+1:2];
  assign bus.mem_wd          = mem_wd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed test-plan steps followed by random traffic,
// checked against a word-array reference model.
module tb_load_store_unit;

  localparam int DMA = 9;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  load_store_unit_if #(.DM_ADDRESS(DMA), .DATA_W(32)) bus ();

  load_store_unit #(.DM_ADDRESS(DMA), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // DataMemory model: combinational read, write on posedge; bench preload port
  logic [31:0]    dm [0:511];
  logic           pre_we;
  logic [DMA-1:0] pre_a;
  logic [31:0]    pre_d;
  assign bus.mem_rd = dm[bus.mem_a];
  always @(posedge clk) begin
    if (bus.mem_write) dm[bus.mem_a] <= bus.mem_wd;
    else if (pre_we)   dm[pre_a]     <= pre_d;
  end

  // Activity monitor sampled at the active edge (pre-update values)
  int          n_rd = 0, n_wr = 0, cyc = 0;
  logic [31:0] last_a = '0;
  int          resp_cyc [$];
  logic [31:0] resp_dat [$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_read) n_rd <= n_rd + 1;
    if (bus.mem_write) begin
      n_wr   <= n_wr + 1;
      last_a <= 32'(bus.mem_a);
    end
    if (bus.mem_read) last_a <= 32'(bus.mem_a);
    if (bus.resp_valid) begin
      resp_cyc.push_back(cyc);
      resp_dat.push_back(bus.resp_rdata);
    end
  end

  int checks = 0, errors = 0;
  logic [31:0] ref_mem [0:511];
  logic [31:0] last_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference rules
  function automatic bit ref_fault(input bit w, input logic [2:0] f3, input logic [31:0] a);
    int unsigned sz;
    bit legal;
    if (w) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else   legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    sz = 32'd1 << f3[1:0];
    return !legal || ((a % sz) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [31:0] a);
    int unsigned v, sh;
    v = word;
    if (f3 == 3'd0 || f3 == 3'd4) begin
      sh = (a % 4) * 8;
      v  = (word >> sh) & 32'd255;
      if (f3 == 3'd0 && v >= 128) v = v - 256;
    end else if (f3 == 3'd1 || f3 == 3'd5) begin
      sh = ((a % 4) / 2) * 16;
      v  = (word >> sh) & 32'd65535;
      if (f3 == 3'd1 && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [2:0] f3, input logic [31:0] a);
    int unsigned mask, sh;
    if (f3 == 3'd0) begin
      sh = (a % 4) * 8;
      mask = 32'd255 << sh;
      return (old & ~mask) | ((wd & 32'd255) << sh);
    end else if (f3 == 3'd1) begin
      sh = ((a % 4) / 2) * 16;
      mask = 32'd65535 << sh;
      return (old & ~mask) | ((wd & 32'd65535) << sh);
    end
    return wd;
  endfunction

  // Call at a negedge
  task automatic preload(input int idx, input logic [31:0] v);
    pre_a  = idx[DMA-1:0];
    pre_d  = v;
    pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
    ref_mem[idx] = v;
  endtask

  // One complete transaction; call at a negedge with the unit idle
  task automatic do_req(input bit w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input string tag);
    bit          fault;
    int          idx, exp_lat, exp_nrd, exp_nwr, t, lat, rd0, wr0;
    logic [31:0] exp_rd;
    fault   = ref_fault(w, f3, a);
    idx     = int'((a >> 2) % 512);
    exp_rd  = (w || fault) ? 32'd0 : ref_load(ref_mem[idx], f3, a);
    exp_lat = fault ? 1 : ((!w || f3 == 3'd2) ? 2 : 3);
    exp_nrd = (fault || (w && f3 == 3'd2)) ? 0 : 1;
    exp_nwr = (!fault && w) ? 1 : 0;
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    t = 0;
    while (!bus.req_ready && t < 20) begin @(negedge clk); t++; end
    check({tag, "/accept"}, 32'(t < 20), 32'd1);
    rd0 = n_rd;
    wr0 = n_wr;
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin @(negedge clk); lat++; end
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "/rdata"}, bus.resp_rdata, exp_rd);
    check({tag, "/misaligned"}, 32'(bus.resp_misaligned), 32'(fault));
    check({tag, "/reads"}, 32'(n_rd - rd0), 32'(exp_nrd));
    check({tag, "/writes"}, 32'(n_wr - wr0), 32'(exp_nwr));
    check({tag, "/ready_busy"}, 32'(bus.req_ready), 32'd0);
    if (exp_nrd + exp_nwr > 0) check({tag, "/mem_a"}, last_a, 32'(idx));
    last_rdata = bus.resp_rdata;
    if (!fault && w) ref_mem[idx] = ref_store(ref_mem[idx], wd, f3, a);
    @(negedge clk);
    check({tag, "/mem_word"}, dm[idx], ref_mem[idx]);
    check({tag, "/ready_after"}, 32'(bus.req_ready), 32'd1);
  endtask

  logic [31:0] b2b_addr [3];
  int          n0, t, rsp0;

  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    pre_we         = 1'b0;
    pre_a          = '0;
    pre_d          = '0;
    for (int i = 0; i < 512; i++) ref_mem[i] = '0;

    // Reset state
    @(negedge clk);
    check("rst/ready", 32'(bus.req_ready), 32'd0);
    check("rst/mem_read", 32'(bus.mem_read), 32'd0);
    check("rst/mem_write", 32'(bus.mem_write), 32'd0);
    check("rst/resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst/resp_rdata", bus.resp_rdata, 32'd0);
    check("rst/misaligned", 32'(bus.resp_misaligned), 32'd0);
    for (int i = 0; i < 16; i++) preload(i, $urandom);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst/ready_after", 32'(bus.req_ready), 32'd1);
    check("rst/mem_a", 32'(bus.mem_a), 32'd0);
    check("rst/mem_wd", bus.mem_wd, 32'd0);
    check("rst/resp_valid_after", 32'(bus.resp_valid), 32'd0);

    // Word round-trip
    do_req(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, "sw");
    check("sw/mem_a4", last_a, 32'd4);
    do_req(1'b0, 3'b010, 32'h0000_0010, 32'h0, "lw");
    check("lw/value", last_rdata, 32'hDEAD_BEEF);

    // Sub-word read-modify-write
    preload(4, 32'h1122_3344);
    do_req(1'b1, 3'b000, 32'h0000_0011, 32'h0000_00AA, "sb");
    check("sb/word4", dm[4], 32'h1122_AA44);
    do_req(1'b1, 3'b001, 32'h0000_0012, 32'h0000_8001, "sh");
    check("sh/word4", dm[4], 32'h8001_AA44);

    // Extension
    preload(8, 32'h80FF_7F01);
    do_req(1'b0, 3'b000, 32'h20, 32'h0, "lb20");
    check("lb20/value", last_rdata, 32'h0000_0001);
    do_req(1'b0, 3'b000, 32'h23, 32'h0, "lb23");
    check("lb23/value", last_rdata, 32'hFFFF_FF80);
    do_req(1'b0, 3'b100, 32'h23, 32'h0, "lbu23");
    check("lbu23/value", last_rdata, 32'h0000_0080);
    do_req(1'b0, 3'b001, 32'h22, 32'h0, "lh22");
    check("lh22/value", last_rdata, 32'hFFFF_80FF);
    do_req(1'b0, 3'b101, 32'h22, 32'h0, "lhu22");
    check("lhu22/value", last_rdata, 32'h0000_80FF);

    // Faults
    do_req(1'b0, 3'b010, 32'h21, 32'h0, "flw21");
    do_req(1'b1, 3'b001, 32'h13, 32'h5555, "fsh13");
    check("fsh13/word4", dm[4], 32'h8001_AA44);
    do_req(1'b0, 3'b011, 32'h20, 32'h0, "fld011");

    // Reset in the WR cycle of an SB
    preload(5, 32'hCAFE_F00D);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h15;
    bus.req_wdata  = 32'h77;
    check("rstwr/ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rstwr/rd_cycle", 32'(bus.mem_read), 32'd1);
    @(negedge clk);
    check("rstwr/wr_cycle", 32'(bus.mem_write), 32'd1);
    rst_n = 1'b0;
    rsp0  = resp_cyc.size();
    #1;
    check("rstwr/mem_write_gated", 32'(bus.mem_write), 32'd0);
    check("rstwr/ready_gated", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstwr/ready_back", 32'(bus.req_ready), 32'd1);
    check("rstwr/no_resp", 32'(resp_cyc.size()), 32'(rsp0));
    check("rstwr/word5", dm[5], 32'hCAFE_F00D);

    // Back-to-back loads with req_valid held high
    b2b_addr[0] = 32'h10;
    b2b_addr[1] = 32'h20;
    b2b_addr[2] = 32'h14;
    n0 = resp_cyc.size();
    for (int k = 0; k < 3; k++) begin
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b0;
      bus.req_funct3 = 3'b010;
      bus.req_addr   = b2b_addr[k];
      t = 0;
      while (!bus.req_ready && t < 20) begin @(negedge clk); t++; end
      check("b2b/wait", 32'(t), (k == 0) ? 32'd0 : 32'd2);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("b2b/count", 32'(resp_cyc.size() - n0), 32'd3);
    if (resp_cyc.size() >= n0 + 3) begin
      for (int k = 0; k < 3; k++) begin
        check("b2b/data", resp_dat[n0+k], ref_mem[b2b_addr[k][10:2]]);
        if (k > 0) check("b2b/spacing", 32'(resp_cyc[n0+k] - resp_cyc[n0+k-1]), 32'd3);
      end
    end

    // Random traffic over 16 words with random aliasing bits
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFF_F800) | $urandom_range(0, 63);
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
